// File: rtl/sensor_link_pkg.sv
// Shared types and widths for the sensor link scheduler: link states,
// the queued frame layout and a saturating counter helper.
package sensor_link_pkg;

  localparam int FRAME_W = 98;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    UP    = 2'd1,
    STALE = 2'd2,
    FAULT = 2'd3
  } link_state_t;

  // flags = {gyro_valid, euler_valid}
  typedef struct packed {
    logic [1:0]         flags;
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic signed [15:0] yaw;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
  } sensor_frame_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_link_scheduler_if.sv
// Frame input bundle from the SPI receiver plus the downstream valid/ready
// output stream. master = receiver/consumer side, slave = scheduler.
interface sensor_link_scheduler_if;

  logic                                 frame_stb;
  logic                                 hdr_ok;
  logic                                 euler_valid;
  logic                                 gyro_valid;
  logic signed [15:0]                   roll;
  logic signed [15:0]                   pitch;
  logic signed [15:0]                   yaw;
  logic signed [15:0]                   gyro_x;
  logic signed [15:0]                   gyro_y;
  logic signed [15:0]                   gyro_z;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [sensor_link_pkg::FRAME_W-1:0]  out_frame;

  modport master (
    output frame_stb, hdr_ok, euler_valid, gyro_valid,
    output roll, pitch, yaw, gyro_x, gyro_y, gyro_z,
    output out_ready,
    input  out_valid, out_frame
  );

  modport slave (
    input  frame_stb, hdr_ok, euler_valid, gyro_valid,
    input  roll, pitch, yaw, gyro_x, gyro_y, gyro_z,
    input  out_ready,
    output out_valid, out_frame
  );

endinterface

// File: rtl/sensor_frame_fifo.sv
// First-word fall-through frame FIFO with flush and drop-oldest on overflow.
// The output holds the last head value while empty.
module sensor_frame_fifo
  import sensor_link_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  sensor_frame_t din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          overwrite_i,
  output sensor_frame_t dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sensor_frame_t mem_q [DEPTH];
  sensor_frame_t last_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push, advance_rd;

  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i & ~empty_o & ~flush_i;
  assign drop_o     = ~flush_i & push_i & full_o & ~do_pop & overwrite_i;
  assign do_push    = ~flush_i & push_i & (~full_o | do_pop | overwrite_i);
  // When full the write slot is the head slot, so dropping is just a read advance.
  assign advance_rd = do_pop | drop_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push)    wr_d = wr_q + 1'b1;
      if (advance_rd) rd_d = rd_q + 1'b1;
      if (do_push && !advance_rd)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && advance_rd) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= dout_o;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o = empty_o ? last_q : mem_q[rd_q];

endmodule

// File: rtl/sensor_link_scheduler.sv
// Link supervisor between the SPI receiver and motion logic: watchdog,
// bad-header streak, FAULT recovery, statistics and the outbound frame FIFO.
module sensor_link_scheduler
  import sensor_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_400_000,
  parameter int unsigned MAX_BAD        = 4,
  parameter int unsigned RECOVER_FRAMES = 3,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sensor_link_scheduler_if.slave link,
  input  logic                   clr_cnt,
  output logic [1:0]             link_state,
  output logic                   link_up,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ST_W = $clog2(MAX_BAD + 1);
  localparam int RC_W = $clog2(RECOVER_FRAMES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(MAX_BAD);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(MAX_BAD - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECOVER_FRAMES - 1);

  link_state_t      state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_next;
  logic [ST_W-1:0]  streak_q, streak_d;
  logic [RC_W-1:0]  recover_q, recover_d;
  logic [CNT_W-1:0] drop_q, drop_d, err_q, err_d;
  logic             good, bad, fault_hit, recover_done, enq, flush;
  logic             fifo_empty, fifo_drop, unused_full;
  sensor_frame_t    frame_in, head;

  assign good         = link.frame_stb & link.hdr_ok;
  assign bad          = link.frame_stb & ~link.hdr_ok;
  assign fault_hit    = bad && (state_q != FAULT) && (streak_q >= ST_LAST);
  assign recover_done = good && (state_q == FAULT) && (recover_q == RC_LAST);
  // The frame that completes recovery is the first one allowed through again.
  assign enq          = good && (link.euler_valid || link.gyro_valid)
                        && ((state_q != FAULT) || recover_done);
  assign wd_next      = link.frame_stb ? '0 : ((wd_q == WD_LAST) ? wd_q : wd_q + 1'b1);

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    streak_d  = streak_q;
    recover_d = recover_q;
    flush     = 1'b0;

    if (good)                           streak_d = '0;
    else if (bad && streak_q != ST_MAX) streak_d = streak_q + 1'b1;

    unique case (state_q)
      INIT: begin
        wd_d = '0;
        if (fault_hit) begin
          state_d = FAULT;
          flush   = 1'b1;
        end else if (good) begin
          state_d = UP;
        end
      end
      UP: begin
        wd_d = wd_next;
        if (fault_hit) begin
          state_d = FAULT;
          flush   = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = STALE;
        end
      end
      STALE: begin
        wd_d = wd_next;
        if (fault_hit) begin
          state_d = FAULT;
          flush   = 1'b1;
        end else if (good) begin
          state_d = UP;
        end
      end
      FAULT: begin
        wd_d = '0;
        if (bad) begin
          recover_d = '0;
        end else if (recover_done) begin
          state_d   = UP;
          recover_d = '0;
        end else if (good) begin
          recover_d = recover_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign err_d  = clr_cnt ? '0 : (bad       ? sat_inc(err_q)  : err_q);
  assign drop_d = clr_cnt ? '0 : (fifo_drop ? sat_inc(drop_q) : drop_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      wd_q      <= '0;
      streak_q  <= '0;
      recover_q <= '0;
      drop_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      streak_q  <= streak_d;
      recover_q <= recover_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  assign frame_in = {link.gyro_valid, link.euler_valid, link.roll, link.pitch, link.yaw,
                     link.gyro_x, link.gyro_y, link.gyro_z};

  sensor_frame_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (enq),
    .din_i      (frame_in),
    .pop_i      (link.out_ready),
    .flush_i    (flush),
    .overwrite_i(1'b1),
    .dout_o     (head),
    .full_o     (unused_full),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

  assign link.out_valid = ~fifo_empty;
  assign link.out_frame = head;
  assign link_state     = state_q;
  assign link_up        = (state_q == UP);
  assign drop_cnt       = drop_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_sensor_link_scheduler.sv
// Directed bench for sensor_link_scheduler with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_sensor_link_scheduler;

  localparam int TMO  = 100;
  localparam int MAXB = 4;
  localparam int REC  = 3;
  localparam int DEP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr_cnt = 1'b0;
  logic [1:0] link_state;
  logic       link_up;
  logic [7:0] drop_cnt, err_cnt;

  sensor_link_scheduler_if L();

  sensor_link_scheduler #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_BAD       (MAXB),
    .RECOVER_FRAMES(REC),
    .DEPTH         (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (L),
    .clr_cnt   (clr_cnt),
    .link_state(link_state),
    .link_up   (link_up),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state as int (0 INIT,1 UP,2 STALE,3 FAULT), queue of frames.
  int           m_state = 0;
  int           m_streak = 0;
  int           m_rec = 0;
  int           m_drop = 0;
  int           m_err = 0;
  longint       m_cyc = 0;
  longint       m_last_stb = 0;
  logic [97:0]  m_q[$];
  logic         mg, mb, mpop, mfault, mrecd, mtmo, menq, mdropped;
  logic [97:0]  mfr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_streak = 0; m_rec = 0; m_drop = 0; m_err = 0;
      m_cyc = 0; m_last_stb = 0;
      m_q.delete();
    end else begin
      m_cyc++;
      mg     = L.frame_stb && L.hdr_ok;
      mb     = L.frame_stb && !L.hdr_ok;
      mfr    = {L.gyro_valid, L.euler_valid, L.roll, L.pitch, L.yaw, L.gyro_x, L.gyro_y, L.gyro_z};
      mpop   = (m_q.size() > 0) && L.out_ready;
      mfault = mb && (m_state != 3) && (m_streak + 1 >= MAXB);
      mrecd  = mg && (m_state == 3) && (m_rec + 1 == REC);
      mtmo   = (m_state == 1) && ((m_cyc - m_last_stb) >= TMO);
      menq   = mg && (L.euler_valid || L.gyro_valid) && ((m_state != 3) || mrecd);
      mdropped = 1'b0;
      if (mfault) m_q.delete();
      else begin
        if (mpop) void'(m_q.pop_front());
        if (menq) begin
          if (m_q.size() == DEP) begin
            void'(m_q.pop_front());
            mdropped = 1'b1;
          end
          m_q.push_back(mfr);
        end
      end
      if (clr_cnt) begin m_err = 0; m_drop = 0; end
      else begin
        if (mb && m_err < 255) m_err++;
        if (mdropped && m_drop < 255) m_drop++;
      end
      if (m_state == 3) begin
        if (mb) m_rec = 0;
        else if (mrecd) m_rec = 0;
        else if (mg) m_rec++;
      end else m_rec = 0;
      if (mfault) m_state = 3;
      else case (m_state)
        0: if (mg) m_state = 1;
        1: if (mtmo) m_state = 2;
        2: if (mg) m_state = 1;
        3: if (mrecd) m_state = 1;
        default: m_state = 0;
      endcase
      if (mg) m_streak = 0;
      else if (mb && m_streak < MAXB) m_streak++;
      if (L.frame_stb) m_last_stb = m_cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", link_state, m_state);
      chk("link_up", link_up, m_state == 1);
      chk("out_valid", L.out_valid, m_q.size() > 0);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("err_cnt", err_cnt, m_err);
      if (m_q.size() > 0) chk("head", L.out_frame, m_q[0]);
    end
  end

  task automatic drive(input logic hdr, input logic ev, input logic gv,
                       input logic [15:0] tag, input logic rdy, input logic clr);
    L.frame_stb = 1'b1; L.hdr_ok = hdr; L.euler_valid = ev; L.gyro_valid = gv;
    L.roll = tag; L.pitch = tag + 16'd1; L.yaw = tag + 16'd2;
    L.gyro_x = ~tag; L.gyro_y = tag ^ 16'h5555; L.gyro_z = {tag[14:0], 1'b0};
    L.out_ready = rdy; clr_cnt = clr;
    @(posedge clk); #1;
    L.frame_stb = 1'b0; L.hdr_ok = 1'b0; L.out_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic good(input logic [15:0] tag); drive(1'b1, 1'b1, 1'b1, tag, 1'b0, 1'b0); endtask
  task automatic bad(input logic [15:0] tag);  drive(1'b0, 1'b1, 1'b1, tag, 1'b0, 1'b0); endtask

  task automatic pop_one();
    L.out_ready = 1'b1;
    @(posedge clk); #1;
    L.out_ready = 1'b0;
  endtask

  logic        rec_hdr [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] drain_tag [4] = '{16'h1004, 16'h1005, 16'h1006, 16'h1007};

  initial begin
    L.frame_stb = 0; L.hdr_ok = 0; L.euler_valid = 0; L.gyro_valid = 0;
    L.roll = 0; L.pitch = 0; L.yaw = 0; L.gyro_x = 0; L.gyro_y = 0; L.gyro_z = 0;
    L.out_ready = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_state", link_state, 2'd0);
    chk("rst_valid", L.out_valid, 1'b0);
    chk("rst_frame", L.out_frame, 98'd0);
    chk("rst_link_up", link_up, 1'b0);
    chk("rst_cnts", {drop_cnt, err_cnt}, 16'd0);

    // First good frame: INIT -> UP, visible one cycle after the strobe
    good(16'h0123);
    chk("s1_state", link_state, 2'd1);
    chk("s1_valid", L.out_valid, 1'b1);
    chk("s1_roll", L.out_frame[95:80], 16'h0123);
    chk("s1_flags", L.out_frame[97:96], 2'b11);
    pop_one();
    chk("s1_popped", L.out_valid, 1'b0);

    // Watchdog timeout to STALE keeps the FIFO, flagless frame restores UP
    good(16'h0200);
    repeat (99) @(posedge clk);
    #1 chk("s2_up_99", link_state, 2'd1);
    @(posedge clk); #1;
    chk("s2_stale", link_state, 2'd2);
    chk("s2_link_up", link_up, 1'b0);
    chk("s2_kept", L.out_frame[95:80], 16'h0200);
    drive(1'b1, 1'b0, 1'b0, 16'h02FF, 1'b0, 1'b0);
    chk("s2_back_up", link_state, 2'd1);
    chk("s2_noflag_head", L.out_frame[95:80], 16'h0200);
    good(16'h0300);

    // Four bad frames: FAULT, flush; then recovery sequence
    repeat (3) bad(16'hBAD1);
    chk("s3_still_up", link_state, 2'd1);
    bad(16'hBAD1);
    chk("s3_fault", link_state, 2'd3);
    chk("s3_err", err_cnt, 8'd4);
    chk("s3_flushed", L.out_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(rec_hdr[i], 1'b1, 1'b1, 16'h0401 + 16'(i), 1'b0, 1'b0);
      chk("s3_hold_fault", link_state, 2'd3);
    end
    good(16'h0600);
    chk("s3_recovered", link_state, 2'd1);
    chk("s3_head", L.out_frame[95:80], 16'h0600);
    chk("s3_err5", err_cnt, 8'd5);
    pop_one();
    chk("s3_only_one", L.out_valid, 1'b0);

    // Overflow with no pop drops the oldest
    for (int i = 1; i <= 6; i++) good(16'h1000 + 16'(i));
    chk("s4_drop", drop_cnt, 8'd2);
    chk("s4_head", L.out_frame[95:80], 16'h1003);

    // Full + push + pop: no drop, head advances
    drive(1'b1, 1'b1, 1'b1, 16'h1007, 1'b1, 1'b0);
    chk("s5_drop", drop_cnt, 8'd2);
    chk("s5_head", L.out_frame[95:80], 16'h1004);
    for (int i = 0; i < 4; i++) begin
      chk("s5_drain_valid", L.out_valid, 1'b1);
      chk("s5_drain_head", L.out_frame[95:80], drain_tag[i]);
      pop_one();
    end
    chk("s5_drained", L.out_valid, 1'b0);

    // err_cnt saturation and clr_cnt priority
    repeat (250) bad(16'hBAD2);
    chk("s6_err255", err_cnt, 8'd255);
    chk("s6_fault", link_state, 2'd3);
    bad(16'hBAD3);
    chk("s6_err_sat", err_cnt, 8'd255);
    drive(1'b0, 1'b1, 1'b1, 16'hBAD4, 1'b0, 1'b1);
    chk("s6_clr_err", err_cnt, 8'd0);
    chk("s6_clr_drop", drop_cnt, 8'd0);
    for (int i = 1; i <= 3; i++) good(16'h2000 + 16'(i));
    chk("s6_up", link_state, 2'd1);
    bad(16'hBAD5);
    chk("s6_err1", err_cnt, 8'd1);
    for (int i = 5; i <= 8; i++) good(16'h2000 + 16'(i));
    chk("s6_drop1", drop_cnt, 8'd1);
    chk("s6_head", L.out_frame[95:80], 16'h2005);

    // Asynchronous reset mid-queue
    #3 rst_n = 1'b0;
    #1;
    chk("ar_state", link_state, 2'd0);
    chk("ar_valid", L.out_valid, 1'b0);
    chk("ar_frame", L.out_frame, 98'd0);
    chk("ar_link_up", link_up, 1'b0);
    chk("ar_cnts", {drop_cnt, err_cnt}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    good(16'h3001);
    chk("post_state", link_state, 2'd1);
    chk("post_head", L.out_frame[95:80], 16'h3001);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_link_scheduler.md
Name: sensor_link_scheduler

Overview:
Sits between the Arduino SPI receiver and the downstream motion/trigger logic, in the FPGA system clock domain. Consumes the receiver's per-packet update strobe and parsed fields. Supervises link health with a watchdog, a bad-header streak counter and a recovery counter. Queues accepted frames in a small FIFO that downstream drains through a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 2_400_000, clk cycles without any strobe before UP goes to STALE (50 ms at 48 MHz).
MAX_BAD, 4, consecutive bad-header frames that force FAULT.
RECOVER_FRAMES, 3, consecutive good frames needed to leave FAULT.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
frame_stb  in  1  one-cycle pulse, asserted one cycle after the receiver outputs update
hdr_ok  in  1  header byte of this frame equals 0xAA; qualified by frame_stb
euler_valid  in  1  frame flag bit 0
gyro_valid  in  1  frame flag bit 1
roll, pitch, yaw  in  16 signed each  Euler angles, 0.01 deg units
gyro_x, gyro_y, gyro_z  in  16 signed each  rates, scaled by 2000
clr_cnt  in  1  synchronous clear of both counters
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts the head entry
out_frame  out  98  {flags[1:0], roll, pitch, yaw, gyro_x, gyro_y, gyro_z}, FIFO head
link_state  out  2  INIT=0, UP=1, STALE=2, FAULT=3
link_up  out  1  high when link_state is UP
drop_cnt  out  8  saturating count of overwritten frames
err_cnt  out  8  saturating count of bad-header frames

Behaviour:
- Reset (async, rst_n low): state INIT, FIFO empty, out_valid 0, out_frame 0, link_up 0, all counters 0 (watchdog, bad streak, recover, drop_cnt, err_cnt).
- Good frame: frame_stb high and hdr_ok high. Bad frame: frame_stb high and hdr_ok low.
- Bad streak:
  - Increments on each bad frame, saturating at MAX_BAD.
  - Clears on each good frame.
- Watchdog:
  - Clears on any frame_stb.
  - Otherwise increments, saturating.
  - Counts only in UP and STALE; held at 0 in INIT and FAULT.
- State machine, with transitions registered on the cycle after the triggering event:
  - INIT: good frame goes to UP. Bad streak reaching MAX_BAD goes to FAULT.
  - UP: watchdog reaching TIMEOUT_CYCLES-1 goes to STALE. Bad streak reaching MAX_BAD goes to FAULT.
  - STALE: good frame goes to UP. Bad streak reaching MAX_BAD goes to FAULT.
  - FAULT:
    - The recover counter counts good frames; any bad frame clears it to 0.
    - Recover reaching RECOVER_FRAMES goes to UP and clears recover.
  - The FAULT condition has priority over the timeout when both occur on the same cycle.
- Enqueue condition:
  - frame_stb and hdr_ok, and at least one of euler_valid or gyro_valid.
  - State is not FAULT, except the good frame that completes recovery, which is enqueued.
  - Frames with both flags 0 update the watchdog and state but are not enqueued.
- FIFO timing:
  - Registered write, first-word fall-through read.
  - out_valid rises the cycle after the enqueueing frame_stb.
  - Pop when out_valid and out_ready are both high.
- Full plus push, with no pop that cycle: drop the oldest entry (advance the read pointer), write the new entry, increment drop_cnt. Occupancy stays at DEPTH.
- Full plus push plus pop on the same cycle: normal push and pop, no drop.
- Empty plus push plus out_ready high: out_valid is still 0 that cycle, so there is no pop.
- Entering FAULT flushes the FIFO on the transition cycle; out_valid goes 0 the next cycle. Entering STALE does not flush.
- err_cnt increments on every bad frame in any state.
- drop_cnt and err_cnt both saturate at 255.
- clr_cnt zeroes both counters and wins over a coincident increment.
- out_frame holds its last value while out_valid is 0. Downstream must not sample it then.

Decomposition:
- Package sensor_link_pkg:
  - link_state_t enum (INIT, UP, STALE, FAULT)
  - packed struct sensor_frame_t (flags, roll, pitch, yaw, gyro_x, gyro_y, gyro_z)
  - FRAME_W = 98
  - CNT_W = 8
- Sub-module sensor_frame_fifo:
  - parameterised DEPTH, element type sensor_frame_t
  - ports: push, pop, flush, overwrite-on-full, full, empty, drop pulse
- The top-level block holds the FSM, watchdog, streak and recover counters, and statistics.

Test Plan:
All scenarios use TIMEOUT_CYCLES=100, MAX_BAD=4, RECOVER_FRAMES=3, DEPTH=4.
- Reset, then one good frame (roll=0x0123, both flags 1): link_state goes INIT to UP; out_valid is 1 one cycle after frame_stb; out_frame roll=0x0123; pop with out_ready leaves the FIFO empty.
- UP, then 100 idle cycles: link_state=STALE on the 100th cycle with link_up 0 and FIFO contents retained; one good frame returns the state to UP.
- Four consecutive bad frames from UP with 2 entries queued: err_cnt=4, FIFO flushed, state FAULT. Then good, good, bad, good, good, good: stays in FAULT until the sixth frame, then UP with only that frame queued.
- Six good frames with out_ready held 0: occupancy 4, drop_cnt=2, and the head is frame 3 (frames 1-2 overwritten).
- FIFO full plus push with out_ready=1 on the same cycle: drop_cnt unchanged, occupancy stays 4, head advances by one.
- err_cnt at 255 plus a bad frame: stays at 255. clr_cnt on the same cycle as a bad frame: err_cnt=0. rst_n asserted mid-queue: all outputs return to their reset values immediately (async).
